// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h7800_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT    = 2'b01,
    DISCARD = 2'b10
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular-buffer FIFO for prefetched {pc, instr} entries with synchronous clear.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [63:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_empty,
  output logic o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // Pointers and occupancy; clear wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !i_clr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: one-outstanding-read fetch FSM feeding a prefetch FIFO, with
// redirect/flush, stall and interrupt-instruction injection.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN     = FETCH_XLEN,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h1000_2000,
  parameter logic [XLEN-1:0]  PC_INC   = 32'd4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_stall,
  input  logic            i_int_req,
  input  logic [XLEN-1:0] i_int_inst,
  output logic            o_int_ack,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_ready,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_instr_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc_out
);

  localparam logic [XLEN-1:0] PC_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] w_fetch_pc_nxt;
  logic            r_int_pending;
  logic            w_int_pending_nxt;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;
  logic            w_empty;
  logic            w_full;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_int_ack;
  logic            w_instr_valid;

  // A request is only issued with a free slot, so an in-flight response always fits.
  assign o_mem_req     = rst_n && (r_state == IDLE) && !w_full && !i_redirect;
  assign o_mem_addr    = r_fetch_pc;
  assign w_accept      = o_mem_req && i_mem_ready;
  assign w_push        = (r_state == WAIT) && i_mem_rvalid && !i_redirect;
  assign w_instr_valid = !i_redirect && (r_int_pending || !w_empty);
  assign w_pop         = !w_empty && !i_redirect && !i_stall && !r_int_pending;
  assign w_int_ack     = r_int_pending && !i_stall && !i_redirect;
  assign w_push_entry  = '{pc: r_fetch_pc, instr: i_mem_rdata};
  assign o_int_ack     = w_int_ack;
  assign o_instr_valid = w_instr_valid;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (i_redirect),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // State, fetch address and interrupt-pending registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_fetch_pc    <= RESET_PC;
      r_int_pending <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_int_pending <= w_int_pending_nxt;
    end
  end

  // Next-state logic for the fetch FSM, fetch_pc and interrupt pending.
  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_int_pending_nxt = r_int_pending;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = i_redirect ? DISCARD : WAIT;
        else          w_state_nxt = IDLE;
      end
      WAIT: begin
        if (i_mem_rvalid)    w_state_nxt = IDLE;
        else if (i_redirect) w_state_nxt = DISCARD;
        else                 w_state_nxt = WAIT;
      end
      DISCARD: begin
        if (i_mem_rvalid) w_state_nxt = IDLE;
        else              w_state_nxt = DISCARD;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (i_redirect)  w_fetch_pc_nxt = i_redirect_pc & PC_ALIGN_MASK;
    else if (w_push) w_fetch_pc_nxt = r_fetch_pc + PC_INC;
    else             w_fetch_pc_nxt = r_fetch_pc;
    // A request still high in the ack cycle must not immediately re-arm.
    if (w_int_ack)      w_int_pending_nxt = 1'b0;
    else if (i_int_req) w_int_pending_nxt = 1'b1;
    else                w_int_pending_nxt = r_int_pending;
  end

  // Output mux: injected instruction overrides the FIFO head while pending.
  always_comb begin
    o_instr  = NOP_INSTR;
    o_pc_out = '0;
    if (!w_instr_valid) begin
      o_instr  = NOP_INSTR;
      o_pc_out = '0;
    end else if (r_int_pending) begin
      o_instr  = i_int_inst;
      o_pc_out = w_empty ? r_fetch_pc : w_head.pc;
    end else begin
      o_instr  = w_head.instr;
      o_pc_out = w_head.pc;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based reference model of the fetch stage and a latency-modelled memory.
module tb_fetch_prefetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h1000_2000;
  localparam logic [31:0] NOP      = 32'h7800_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        int_req;
  logic [31:0] int_inst;
  logic        int_ack;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;

  always #5 clk = ~clk;

  fetch_prefetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_stall       (stall),
    .i_int_req     (int_req),
    .i_int_inst    (int_inst),
    .o_int_ack     (int_ack),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .i_mem_ready   (mem_ready),
    .i_mem_rvalid  (mem_rvalid),
    .i_mem_rdata   (mem_rdata),
    .o_instr_valid (instr_valid),
    .o_instr       (instr),
    .o_pc_out      (pc_out)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  int          checks   = 0;
  int          failures = 0;
  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_pend;
  bit          m_discard;
  bit          mb_busy;
  int          mb_cnt;
  logic [31:0] mb_addr;
  int          mem_lat;
  bit          lat_rand;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memdat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc      = RESET_PC;
    m_pend    = 1'b0;
    m_discard = 1'b0;
    mb_busy   = 1'b0;
    mb_cnt    = 0;
    mb_addr   = 32'd0;
  endtask

  task automatic reset_checks();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_int_ack", 32'(int_ack), 32'd0);
  endtask

  // One clock: drive memory, check outputs against the model, advance the model.
  task automatic cycle();
    logic        e_req;
    logic        e_valid;
    logic        e_ack;
    logic        acc;
    logic        rsp;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] pc_before;
    ent_t        e;
    if (mb_busy && mb_cnt == 1) begin
      mem_rvalid = 1'b1;
      mem_rdata  = memdat(mb_addr);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    #1;
    pc_before = m_pc;
    e_req   = !mb_busy && (q.size() < DEPTH) && !redirect;
    e_valid = !redirect && (m_pend || q.size() != 0);
    e_ack   = m_pend && !stall && !redirect;
    e_instr = NOP;
    e_pc    = 32'd0;
    if (e_valid) begin
      if (m_pend) begin
        e_instr = int_inst;
        e_pc    = (q.size() != 0) ? q[0].pc : m_pc;
      end else begin
        e_instr = q[0].ins;
        e_pc    = q[0].pc;
      end
    end
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("mem_addr", mem_addr, m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(e_valid));
    chk("instr", instr, e_instr);
    chk("pc_out", pc_out, e_pc);
    chk("int_ack", 32'(int_ack), 32'(e_ack));
    acc = e_req && mem_ready;
    rsp = mb_busy && mem_rvalid;
    if (redirect) begin
      q.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      if (mb_busy && !rsp) m_discard = 1'b1;
    end else begin
      if (e_valid && !stall && !m_pend) void'(q.pop_front());
      if (rsp && !m_discard) begin
        e.pc  = m_pc;
        e.ins = mem_rdata;
        q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    if (rsp) m_discard = 1'b0;
    if (e_ack)        m_pend = 1'b0;
    else if (int_req) m_pend = 1'b1;
    if (rsp)          mb_busy = 1'b0;
    else if (mb_busy) mb_cnt--;
    if (acc) begin
      mb_busy = 1'b1;
      mb_cnt  = lat_rand ? int'($urandom_range(1, 3)) : mem_lat;
      mb_addr = pc_before;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; stall = 1'b0;
    int_req = 1'b0; int_inst = 32'd0; mem_ready = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0; mem_lat = 1; lat_rand = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;

    // T1: enter WAIT on a slow read, then reset mid-WAIT; response is abandoned.
    mem_ready = 1'b1; mem_lat = 3;
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    reset_checks();
    model_reset();
    mem_rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // T2: streaming with 1-cycle memory.
    mem_lat = 1;
    repeat (14) cycle();

    // T3: long stall fills the FIFO, then drains in order.
    stall = 1'b1;
    repeat (20) cycle();
    stall = 1'b0;
    repeat (10) cycle();

    // T4: redirect while a 3-cycle read is in flight; unaligned target.
    mem_lat = 3;
    for (int i = 0; i < 8 && !mb_busy; i++) cycle();
    redirect = 1'b1; redirect_pc = 32'h2000_0003;
    cycle();
    redirect = 1'b0; mem_lat = 1;
    repeat (12) cycle();

    // fetch_pc wrap-around at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect = 1'b0;
    repeat (10) cycle();

    // T5: interrupt while FIFO holds 0x100, 0x104.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0100;
    cycle();
    redirect = 1'b0;
    repeat (4) cycle();
    int_req = 1'b1; int_inst = 32'hDEAD_BEEF;
    cycle();
    int_req = 1'b0;
    cycle();
    stall = 1'b0;
    repeat (8) cycle();

    // T6: redirect in the cycle the interrupt would be consumed.
    stall = 1'b1; int_req = 1'b1; int_inst = 32'h1234_5678;
    cycle();
    int_req = 1'b0; stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0300;
    cycle();
    redirect = 1'b0;
    repeat (4) cycle();

    // Level int_req held high: ignored in the ack cycle, re-arms after.
    int_req = 1'b1; int_inst = 32'hCAFE_F00D;
    repeat (6) cycle();
    int_req = 1'b0;
    repeat (4) cycle();

    // Randomized traffic.
    lat_rand = 1'b1;
    for (int n = 0; n < 600; n++) begin
      redirect    = ($urandom_range(0, 99) < 5);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      stall       = ($urandom_range(0, 99) < 30);
      int_req     = ($urandom_range(0, 99) < 6);
      int_inst    = $urandom;
      mem_ready   = ($urandom_range(0, 99) < 75);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
